// File: rtl/comb_sel_pkg.sv
// Shared types and the priority decode for the comb_sel_skid consumer stage.
// Optional feature macro used by this slice: COMB_SEL_SKID_PARITY_EN.
package comb_sel_pkg;

    // Source code carried alongside each buffered value; NONE marks an empty head.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        SRC1 = 2'd1,
        SRC2 = 2'd2,
        SRC3 = 2'd3
    } sel_t;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Priority decode: src2[0] wins, then src3[0], otherwise fall back to src1.
    function automatic sel_t sel_code(input logic src2_lsb, input logic src3_lsb);
        sel_t code;
        if (src2_lsb) begin
            code = SRC2;
        end else if (src3_lsb) begin
            code = SRC3;
        end else begin
            code = SRC1;
        end
        return code;
    endfunction

endpackage

// File: rtl/comb_sel_mux.sv
// Combinational priority picker: turns one src1/src2/src3 triple into the
// selected value and its source code. Sits upstream of the buffer registers.
module comb_sel_mux
    import comb_sel_pkg::*;
#(
    parameter int SIZE = 1
) (
    input  logic [SIZE-1:0] src1_i,
    input  logic [SIZE-1:0] src2_i,
    input  logic [SIZE-1:0] src3_i,
    output logic [SIZE-1:0] data_o,
    output sel_t            sel_o
);

    sel_t sel_s;

    // Decode the source from the two LSBs and steer the matching operand.
    always_comb begin
        sel_s  = sel_code(src2_i[0], src3_i[0]);
        data_o = src1_i;
        case (sel_s)
            SRC1:    data_o = src1_i;
            SRC2:    data_o = src2_i;
            SRC3:    data_o = src3_i;
            default: data_o = src1_i;
        endcase
        sel_o = sel_s;
    end

endmodule

// File: rtl/comb_sel_skid.sv
// comb_sel_skid: registered consumer stage. Accepts one triple per valid/ready
// handshake, resolves the priority select and queues the result in a 2-entry
// skid buffer (head + skid) feeding a downstream valid/ready sink. Also keeps
// a saturating count of src2-selected accepts.
// Optional feature: define COMB_SEL_SKID_PARITY_EN to add out_par, a parity
// bit computed at accept time and stored alongside each entry.
module comb_sel_skid
    import comb_sel_pkg::*;
#(
    parameter int size  = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [size-1:0]  src1,
    input  logic [size-1:0]  src2,
    input  logic [size-1:0]  src3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [size-1:0]  out_data,
    output logic [1:0]       out_sel,
`ifdef COMB_SEL_SKID_PARITY_EN
    output logic             out_par,
`endif
    output logic [CNT_W-1:0] hit_cnt
);

    state_t            state_q;
    state_t            state_d;
    logic [size-1:0]   head_data_q;
    sel_t              head_sel_q;
    logic [size-1:0]   skid_data_q;
    sel_t              skid_sel_q;
    logic [CNT_W-1:0]  hit_cnt_q;

    logic [size-1:0]   mux_data_s;
    sel_t              mux_sel_s;
    logic              in_ready_s;
    logic              out_valid_s;
    logic              accept_s;
    logic              emit_s;
    logic              head_ld_new_s;
    logic              head_ld_skid_s;
    logic              head_clr_s;
    logic              skid_ld_s;
    logic              skid_clr_s;

    comb_sel_mux #(
        .SIZE (size)
    ) u_mux (
        .src1_i (src1),
        .src2_i (src2),
        .src3_i (src3),
        .data_o (mux_data_s),
        .sel_o  (mux_sel_s)
    );

    // Handshake flags come from the state register only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready_s  = (state_q != TWO);
    assign out_valid_s = (state_q != EMPTY);
    assign accept_s    = in_valid & in_ready_s;
    assign emit_s      = out_valid_s & out_ready;

    // Next-state and load-enable decode for the head/skid pair.
    always_comb begin
        state_d        = state_q;
        head_ld_new_s  = 1'b0;
        head_ld_skid_s = 1'b0;
        head_clr_s     = 1'b0;
        skid_ld_s      = 1'b0;
        skid_clr_s     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept_s) begin
                    head_ld_new_s = 1'b1;
                    state_d       = ONE;
                end else begin
                    state_d       = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && emit_s) begin
                    head_ld_new_s = 1'b1;
                    state_d       = ONE;
                end else if (accept_s) begin
                    skid_ld_s     = 1'b1;
                    state_d       = TWO;
                end else if (emit_s) begin
                    // Clear the head so an empty buffer shows out_sel=NONE.
                    head_clr_s    = 1'b1;
                    state_d       = EMPTY;
                end else begin
                    state_d       = ONE;
                end
            end
            TWO: begin
                if (emit_s) begin
                    head_ld_skid_s = 1'b1;
                    skid_clr_s     = 1'b1;
                    state_d        = ONE;
                end else begin
                    state_d        = TWO;
                end
            end
            default: begin
                head_clr_s = 1'b1;
                skid_clr_s = 1'b1;
                state_d    = EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Head entry: fresh triple, promoted skid entry, or cleared when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data_q <= {size{1'b0}};
            head_sel_q  <= NONE;
        end else if (head_ld_new_s) begin
            head_data_q <= mux_data_s;
            head_sel_q  <= mux_sel_s;
        end else if (head_ld_skid_s) begin
            head_data_q <= skid_data_q;
            head_sel_q  <= skid_sel_q;
        end else if (head_clr_s) begin
            head_data_q <= {size{1'b0}};
            head_sel_q  <= NONE;
        end
    end

    // Skid entry: catches a triple while the head is stalled; cleared once promoted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_q <= {size{1'b0}};
            skid_sel_q  <= NONE;
        end else if (skid_ld_s) begin
            skid_data_q <= mux_data_s;
            skid_sel_q  <= mux_sel_s;
        end else if (skid_clr_s) begin
            skid_data_q <= {size{1'b0}};
            skid_sel_q  <= NONE;
        end
    end

    // Saturating count of accepted src2-selected triples; emits do not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= {CNT_W{1'b0}};
        end else if (accept_s && (mux_sel_s == SRC2) && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end
    end

`ifdef COMB_SEL_SKID_PARITY_EN
    logic head_par_q;
    logic skid_par_q;

    function automatic logic par_of(input logic [size-1:0] d);
        return ^d;
    endfunction

    // Parity is captured with the data at accept time and follows it through the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_par_q <= 1'b0;
            skid_par_q <= 1'b0;
        end else begin
            if (head_ld_new_s) begin
                head_par_q <= par_of(mux_data_s);
            end else if (head_ld_skid_s) begin
                head_par_q <= skid_par_q;
            end else if (head_clr_s) begin
                head_par_q <= 1'b0;
            end
            if (skid_ld_s) begin
                skid_par_q <= par_of(mux_data_s);
            end else if (skid_clr_s) begin
                skid_par_q <= 1'b0;
            end
        end
    end

    assign out_par = head_par_q;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_data  = head_data_q;
    assign out_sel   = head_sel_q;
    assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_comb_sel_skid.sv
// Self-checking bench for comb_sel_skid (size=4, CNT_W=2): a vector table for
// single transfers plus hand-written sequences for stall, streaming,
// saturation and asynchronous reset. A queue scoreboard tracks buffer contents.
module tb_comb_sel_skid;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] sel;
    } exp_t;

    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] s3;
        logic [3:0] e_data;
        logic [1:0] e_sel;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] src1, src2, src3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;
    logic [1:0] hit_cnt;
`ifdef COMB_SEL_SKID_PARITY_EN
    logic       out_par;
`endif

    exp_t sb_q[$];
    exp_t drv_exp;
    int   exp_hit  = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   emit_cnt = 0;

    comb_sel_skid #(.size(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .src3      (src3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
`ifdef COMB_SEL_SKID_PARITY_EN
        .out_par   (out_par),
`endif
        .hit_cnt   (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3);
        exp_t e;
        if (s2[0])      begin e.data = s2; e.sel = 2'd2; end
        else if (s3[0]) begin e.data = s3; e.sel = 2'd3; end
        else            begin e.data = s1; e.sel = 2'd1; end
        return e;
    endfunction

    task automatic set_in(input logic v, input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3);
        in_valid = v;
        src1 = s1; src2 = s2; src3 = s3;
        drv_exp = model(s1, s2, s3);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        exp_hit = 0;
        step();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: occupancy, handshake flags, counter and emitted data.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("in_ready", in_ready, (sb_q.size() < 2) ? 1 : 0);
            chk("out_valid", out_valid, (sb_q.size() != 0) ? 1 : 0);
            chk("hit_cnt", hit_cnt, exp_hit);
            if (out_valid && out_ready) begin
                emit_cnt++;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_sel", out_sel, e.sel);
`ifdef COMB_SEL_SKID_PARITY_EN
                    chk("out_par", out_par, ^e.data);
`endif
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(drv_exp);
                if (drv_exp.sel == 2'd2 && exp_hit != 3) exp_hit++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[9];
        int   sat_exp[5];
        int   base;
        int   i_drain;

        vecs[0] = '{4'h5, 4'hA, 4'h3, 4'h3, 2'd3};
        vecs[1] = '{4'h5, 4'hB, 4'h3, 4'hB, 2'd2};
        vecs[2] = '{4'h5, 4'h4, 4'h2, 4'h5, 2'd1};
        vecs[3] = '{4'h7, 4'h0, 4'hF, 4'hF, 2'd3};
        vecs[4] = '{4'h9, 4'h1, 4'h0, 4'h1, 2'd2};
        vecs[5] = '{4'hE, 4'h6, 4'h8, 4'hE, 2'd1};
        vecs[6] = '{4'h0, 4'h0, 4'h0, 4'h0, 2'd1};
        vecs[7] = '{4'h6, 4'h0, 4'h0, 4'h6, 2'd1};
        vecs[8] = '{4'h7, 4'h0, 4'h0, 4'h7, 2'd1};
        sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;

        rst_n = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 4'h0, 4'h0, 4'h0);
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Single transfers from the table, one-cycle latency from EMPTY.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, vecs[i].s1, vecs[i].s2, vecs[i].s3);
            step();
            set_in(1'b0, 4'h0, 4'h0, 4'h0);
            chk("vec_valid", out_valid, 1);
            chk("vec_data", out_data, vecs[i].e_data);
            chk("vec_sel", out_sel, vecs[i].e_sel);
`ifdef COMB_SEL_SKID_PARITY_EN
            chk("vec_par", out_par, ^vecs[i].e_data);
`endif
            step();
        end
        chk("vec_hit", hit_cnt, 2);

        // Stall: fill to TWO, then drain in order.
        do_reset();
        out_ready = 1'b0;
        set_in(1'b1, 4'h0, 4'h1, 4'h0);
        step();
        set_in(1'b1, 4'h0, 4'h3, 4'h0);
        step();
        set_in(1'b0, 4'h0, 4'h0, 4'h0);
        chk("two_in_ready", in_ready, 0);
        chk("two_head", out_data, 4'h1);
        chk("two_hit", hit_cnt, 2);
        step();
        chk("two_hold", out_data, 4'h1);
        out_ready = 1'b1;
        step();
        chk("drain_1", out_data, 4'h3);
        chk("drain_1_sel", out_sel, 2);
        step();
        chk("drain_empty", out_valid, 0);
        chk("drain_sel0", out_sel, 0);

        // Streaming: accept and emit together every cycle while in ONE.
        do_reset();
        out_ready = 1'b1;
        base = emit_cnt;
        for (int i = 0; i < 11; i++) begin
            set_in(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step();
        end
        set_in(1'b0, 4'h0, 4'h0, 4'h0);
        chk("stream_emits", emit_cnt - base, 10);
        step();

        // Counter saturation at CNT_W=2.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 4'h2, 4'h5 + 4'(2 * i), 4'h0);
            step();
            chk("hit_sat", hit_cnt, sat_exp[i]);
        end
        set_in(1'b0, 4'h0, 4'h0, 4'h0);
        step();

        // Asynchronous reset while in TWO.
        do_reset();
        out_ready = 1'b0;
        set_in(1'b1, 4'h0, 4'h9, 4'h0);
        step();
        set_in(1'b1, 4'h0, 4'hD, 4'h0);
        step();
        chk("pre_rst_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        exp_hit = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_sel", out_sel, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_hit_cnt", hit_cnt, 0);
        out_ready = 1'b1;
        set_in(1'b1, 4'h4, 4'h2, 4'h7);
        step();
        rst_n = 1'b1;
        chk("arst_no_accept", out_valid, 0);
        step();
        set_in(1'b0, 4'h0, 4'h0, 4'h0);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 4'h7);
        chk("post_rst_sel", out_sel, 3);

        // Bounded drain of anything left in the buffer.
        i_drain = 0;
        while (sb_q.size() != 0 && i_drain < 20) begin
            step();
            i_drain++;
        end
        chk("final_drain", sb_q.size(), 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/comb_sel_skid.md
Name: comb_sel_skid

Overview:
- Registered consumer stage for the comb_test priority-select datapath.
- Each transfer accepts one src1/src2/src3 triple over a valid/ready handshake.
- Resolves the out5-style priority select (src2[0] first, then src3[0], else src1) and delivers the result through a 2-entry skid buffer to a downstream valid/ready sink.
- Keeps a saturating count of src2-selected transfers for the SYSTEM_VERILOG_MODE systest benches.

Parameters:
- size, 1, data width of src1/src2/src3/out_data (legal 1..8 in systests)
- CNT_W, 8, width of hit_cnt

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  upstream triple valid
- in_ready  output  1  stage can accept a triple
- src1  input  size  default source
- src2  input  size  priority-1 source, selected when src2[0]=1
- src3  input  size  priority-2 source, selected when src2[0]=0 and src3[0]=1
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head
- out_data  output  size  selected value of head entry
- out_sel  output  2  head source code: 1=src1, 2=src2, 3=src3; 0 only when empty
- hit_cnt  output  CNT_W  saturating count of accepted src2-selected triples

Behaviour:
- Select is pure function of one triple: src2[0] ? (src2, 2) : src3[0] ? (src3, 3) : (src1, 1). Applies identically for size=1.
- Accept = in_valid & in_ready; Emit = out_valid & out_ready.
- State machine (state_t): EMPTY, ONE, TWO. Storage: head {data, sel}, skid {data, sel}.
- in_ready = (state != TWO), decoded from the state register only. No combinational path from out_ready.
- out_valid = (state != EMPTY). out_data/out_sel always driven from head.
- EMPTY:
  - Accept: load head, go to ONE.
- ONE:
  - Accept & Emit: load head with the new triple, stay ONE.
  - Accept only: load skid, go to TWO.
  - Emit only: go to EMPTY.
- TWO:
  - Emit: head <= skid, go to ONE.
  - Accept is impossible (in_ready=0).
- Latency: accepted triple is visible on out_* the cycle after Accept when the buffer was EMPTY, or after ONE with a simultaneous Emit. Otherwise it follows in-order behind the existing head.
- Ordering: strict FIFO. No drops, no duplicates.
- Data held stable while out_valid=1 and out_ready=0.
- hit_cnt increments by 1 on each Accept whose select code is 2. It saturates at all-ones and never wraps. It is unaffected by Emit.
- Reset (rst_n low, asynchronous):
  - state=EMPTY; head, skid, out_sel, out_data and hit_cnt all 0; out_valid=0.
  - in_ready reads 1, but no Accept is taken while rst_n=0.
  - Reset mid-transfer discards both entries; no partial output.
- Holding registers head/skid carry no X after reset. A stale skid value is never observable on out_*.

Optional Feature:
- Macro: COMB_SEL_SKID_PARITY_EN.
- Defined:
  - Adds output out_par, 1 bit, equal to the XOR-reduction of out_data.
  - Parity is computed at Accept and stored per entry (head and skid), so it moves with the data.
  - Reset value is 0.
- Undefined: port and storage are absent; all other behaviour is identical.

Decomposition:
- Package comb_sel_pkg:
  - sel_t: 2-bit enum NONE=0, SRC1=1, SRC2=2, SRC3=3
  - state_t: enum EMPTY, ONE, TWO
  - function sel_code (priority decode)
- Sub-module comb_sel_mux: combinational priority picker producing {data, sel_t} from a triple. Instantiated once, upstream of the buffer regs.

Test Plan:
- size=4, out_ready=1, single Accept src1=4'h5, src2=4'hA, src3=4'h3 -> next cycle out_valid=1, out_data=4'h3, out_sel=3; hit_cnt stays 0.
- size=4, out_ready=0, Accept 4'h1 (src2[0]=1) then 4'h3 (src2[0]=1) -> state TWO, in_ready=0; raise out_ready -> outputs 4'h1 then 4'h3 in order; hit_cnt=2.
- size=4, ONE state with simultaneous Accept & Emit every cycle for 10 cycles -> out_valid continuously 1, one output per cycle, in_ready never drops.
- CNT_W=2, 5 Accepts with src2[0]=1 -> hit_cnt reads 1,2,3,3,3.
- rst_n pulsed low for one cycle while state=TWO -> out_valid=0, out_sel=0 and hit_cnt=0 immediately (asynchronous); first Accept after release appears one cycle later.
- COMB_SEL_SKID_PARITY_EN defined, size=3, selected value 3'b110 -> out_par=0; selected value 3'b111 -> out_par=1.
